// File: rtl/rah_app_tx_packer.sv
// rah_app_tx_packer: store-and-forward packetiser for one rah_encoder app slot.
// Buffers one payload packet, then bursts a header word plus the payload gap-free.
module rah_app_tx_packer #(
    parameter int         DATA_WIDTH = 48,
    parameter logic [7:0] APP_ID     = 8'd0,
    parameter int         MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  send_data,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  overflow
);

    localparam int          ADDR_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [1:0] {
        FILL,
        HDR,
        DRAIN
    } state_t;

    state_t                  state;
    logic [15:0]             wr_cnt;
    logic [15:0]             len;
    logic [15:0]             rd_cnt;
    logic [15:0]             len_next;
    logic [ADDR_W-1:0]       rd_addr;
    logic [ADDR_W-1:0]       rd_addr_sel;
    logic [DATA_WIDTH-1:0]   mem [MAX_WORDS];
    logic [DATA_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0]   header;
    logic                    beat;
    logic                    close_pkt;

    assign in_ready    = (state == FILL) && !rst;
    assign beat        = in_valid && in_ready;
    assign len_next    = wr_cnt + 16'd1;
    assign close_pkt   = beat && (in_last || (len_next == MAX_LEN));
    assign rd_addr_sel = (state == FILL) ? '0 : rd_addr;

    always_comb begin
        header                    = '0;
        header[DATA_WIDTH-1 -: 8] = APP_ID;
        header[15:0]              = len_next;
    end

    // Write-first buffer: a single-word packet reads back the word written on the closing edge.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wr_cnt[ADDR_W-1:0]] <= in_data;
        end
        if (beat && (wr_cnt[ADDR_W-1:0] == rd_addr_sel)) begin
            rd_q <= in_data;
        end else begin
            rd_q <= mem[rd_addr_sel];
        end
    end

    // The header goes out on the closing edge itself; rd_q already holds word 0 by then.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            wr_cnt    <= '0;
            len       <= '0;
            rd_cnt    <= '0;
            rd_addr   <= '0;
            send_data <= 1'b0;
            wr_data   <= '0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (close_pkt) begin
                        state     <= HDR;
                        len       <= len_next;
                        wr_cnt    <= '0;
                        rd_addr   <= ADDR_W'(1);
                        send_data <= 1'b1;
                        busy      <= 1'b1;
                        wr_data   <= header;
                        if (!in_last) begin
                            overflow <= 1'b1;
                        end
                    end else if (beat) begin
                        wr_cnt <= len_next;
                    end
                end
                HDR: begin
                    state   <= DRAIN;
                    rd_cnt  <= '0;
                    wr_data <= rd_q;
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
                DRAIN: begin
                    if (rd_cnt == (len - 16'd1)) begin
                        state     <= FILL;
                        send_data <= 1'b0;
                        busy      <= 1'b0;
                        wr_data   <= '0;
                        rd_addr   <= '0;
                    end else begin
                        rd_cnt  <= rd_cnt + 16'd1;
                        wr_data <= rd_q;
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_rah_app_tx_packer.sv
// Directed bench for rah_app_tx_packer: a MAX_WORDS=16 instance for the general cases
// and a MAX_WORDS=8 instance for force-close and full-length packets.
module tb_rah_app_tx_packer;

    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic          in_valid;
    logic          in_last;
    logic [DW-1:0] in_data;

    logic          in_valid_big,   in_ready_big,   send_data_big,   busy_big,   overflow_big;
    logic          in_valid_small, in_ready_small, send_data_small, busy_small, overflow_small;
    logic [DW-1:0] wr_data_big,    wr_data_small;

    logic          cur_ready;
    logic          cur_send;
    logic [DW-1:0] cur_wr_data;

    logic [DW-1:0] cap[$];
    int            capcyc[$];
    int            cyc;
    int            errors;
    int            checks;

    always #5 clk = ~clk;

    assign in_valid_big   = in_valid && !sel;
    assign in_valid_small = in_valid && sel;
    assign cur_ready      = sel ? in_ready_small  : in_ready_big;
    assign cur_send       = sel ? send_data_small : send_data_big;
    assign cur_wr_data    = sel ? wr_data_small   : wr_data_big;

    rah_app_tx_packer #(.DATA_WIDTH(DW), .APP_ID(8'd3), .MAX_WORDS(16)) u_big (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_big), .in_ready(in_ready_big), .in_data(in_data), .in_last(in_last),
        .send_data(send_data_big), .wr_data(wr_data_big), .busy(busy_big), .overflow(overflow_big)
    );

    rah_app_tx_packer #(.DATA_WIDTH(DW), .APP_ID(8'd3), .MAX_WORDS(8)) u_small (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_small), .in_ready(in_ready_small), .in_data(in_data), .in_last(in_last),
        .send_data(send_data_small), .wr_data(wr_data_small), .busy(busy_small), .overflow(overflow_small)
    );

    // Records every word strobed out of the selected instance with its cycle index.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cur_send) begin
                cap.push_back(cur_wr_data);
                capcyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic l, input bit hold);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!cur_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cur_ready) checkOutput("ready_timeout", 64'(cur_ready), 64'd1);
        tick();
        if (!hold) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic waitPulses(input int n, input string tag);
        int k;
        k = 0;
        while (cap.size() < n && k < 200) begin
            tick();
            k++;
        end
        repeat (4) tick();
        checkOutput({tag, "_count"}, 64'(cap.size()), 64'(n));
    endtask

    initial begin
        int n;
        errors   = 0;
        checks   = 0;
        sel      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        rst      = 1'b1;
        $display("[TB] start");

        repeat (3) tick();
        checkOutput("rst_ready_big",    64'(in_ready_big),    64'd0);
        checkOutput("rst_ready_small",  64'(in_ready_small),  64'd0);
        checkOutput("rst_send_big",     64'(send_data_big),   64'd0);
        checkOutput("rst_wr_data_big",  64'(wr_data_big),     64'd0);
        checkOutput("rst_busy_big",     64'(busy_big),        64'd0);
        checkOutput("rst_overflow_big", 64'(overflow_big),    64'd0);
        checkOutput("rst_send_small",   64'(send_data_small), 64'd0);
        checkOutput("rst_ovf_small",    64'(overflow_small),  64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 64'(in_ready_big), 64'd1);

        // single-word packet
        in_valid = 1'b1;
        in_data  = 48'hA5A5;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("single_hdr_send",  64'(send_data_big), 64'd1);
        checkOutput("single_hdr_data",  64'(wr_data_big),   64'h0300_0000_0001);
        checkOutput("single_hdr_busy",  64'(busy_big),      64'd1);
        checkOutput("single_hdr_ready", 64'(in_ready_big),  64'd0);
        tick();
        checkOutput("single_pay_send",  64'(send_data_big), 64'd1);
        checkOutput("single_pay_data",  64'(wr_data_big),   64'h0000_0000_A5A5);
        checkOutput("single_pay_ready", 64'(in_ready_big),  64'd0);
        tick();
        checkOutput("single_end_send",  64'(send_data_big), 64'd0);
        checkOutput("single_end_data",  64'(wr_data_big),   64'd0);
        checkOutput("single_end_busy",  64'(busy_big),      64'd0);
        checkOutput("single_end_ready", 64'(in_ready_big),  64'd1);

        // 10 words with in_valid toggling
        cap.delete();
        capcyc.delete();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(48'(i), (i == 10), 1'b0);
            tick();
        end
        waitPulses(11, "ten");
        checkOutput("ten_hdr", 64'(cap[0]), 64'h0300_0000_000A);
        for (int k = 0; k < 10; k++) checkOutput("ten_word", 64'(cap[k+1]), 64'(k + 1));
        checkOutput("ten_gapless", 64'(capcyc[10] - capcyc[0]), 64'd10);

        // in_valid held across a packet boundary
        cap.delete();
        capcyc.delete();
        applyStimulus(48'h11, 1'b0, 1'b1);
        applyStimulus(48'h22, 1'b1, 1'b1);
        applyStimulus(48'h33, 1'b1, 1'b0);
        waitPulses(5, "hold");
        checkOutput("hold_hdr_a", 64'(cap[0]), 64'h0300_0000_0002);
        checkOutput("hold_w0",    64'(cap[1]), 64'h11);
        checkOutput("hold_w1",    64'(cap[2]), 64'h22);
        checkOutput("hold_hdr_b", 64'(cap[3]), 64'h0300_0000_0001);
        checkOutput("hold_w2",    64'(cap[4]), 64'h33);
        checkOutput("hold_gap",   64'(capcyc[3] - capcyc[0]), 64'd4);

        // reset during the burst of a 6-word packet
        cap.delete();
        capcyc.delete();
        for (int i = 1; i <= 6; i++) applyStimulus(48'(32'h100 + i), (i == 6), 1'b0);
        n = 0;
        while (!(send_data_big && wr_data_big == 48'h103) && n < 50) begin
            tick();
            n++;
        end
        checkOutput("drain_word3", 64'(wr_data_big), 64'h103);
        rst = 1'b1;
        tick();
        checkOutput("midrst_send",  64'(send_data_big), 64'd0);
        checkOutput("midrst_data",  64'(wr_data_big),   64'd0);
        checkOutput("midrst_busy",  64'(busy_big),      64'd0);
        checkOutput("midrst_ready", 64'(in_ready_big),  64'd0);
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("trunc_count", 64'(cap.size()), 64'd4);
        cap.delete();
        capcyc.delete();
        applyStimulus(48'h201, 1'b0, 1'b0);
        applyStimulus(48'h202, 1'b1, 1'b0);
        waitPulses(3, "after_rst");
        checkOutput("after_rst_hdr", 64'(cap[0]), 64'h0300_0000_0002);
        checkOutput("after_rst_w0",  64'(cap[1]), 64'h201);
        checkOutput("after_rst_w1",  64'(cap[2]), 64'h202);

        // back-to-back packets of 1, MAX_WORDS and 5 on the MAX_WORDS=8 instance
        sel = 1'b1;
        #1;
        cap.delete();
        capcyc.delete();
        applyStimulus(48'h401, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) applyStimulus(48'(32'h410 + i), (i == 8), 1'b1);
        for (int i = 1; i <= 5; i++) applyStimulus(48'(32'h420 + i), (i == 5), (i != 5));
        waitPulses(17, "b2b");
        checkOutput("b2b_hdr1",  64'(cap[0]),  64'h0300_0000_0001);
        checkOutput("b2b_p1",    64'(cap[1]),  64'h401);
        checkOutput("b2b_hdr8",  64'(cap[2]),  64'h0300_0000_0008);
        checkOutput("b2b_p8_0",  64'(cap[3]),  64'h411);
        checkOutput("b2b_p8_7",  64'(cap[10]), 64'h418);
        checkOutput("b2b_hdr5",  64'(cap[11]), 64'h0300_0000_0005);
        checkOutput("b2b_p5_0",  64'(cap[12]), 64'h421);
        checkOutput("b2b_p5_4",  64'(cap[16]), 64'h425);
        checkOutput("b2b_ovf",   64'(overflow_small), 64'd0);

        // force-close: 12 words with in_last only on the 12th
        cap.delete();
        capcyc.delete();
        for (int i = 1; i <= 12; i++) applyStimulus(48'(32'h300 + i), (i == 12), (i != 12));
        waitPulses(14, "force");
        checkOutput("force_hdr8", 64'(cap[0]), 64'h0300_0000_0008);
        for (int k = 0; k < 8; k++) checkOutput("force_a", 64'(cap[k+1]), 64'(32'h301 + k));
        checkOutput("force_hdr4", 64'(cap[9]), 64'h0300_0000_0004);
        for (int k = 0; k < 4; k++) checkOutput("force_b", 64'(cap[k+10]), 64'(32'h309 + k));
        checkOutput("force_ovf",       64'(overflow_small), 64'd1);
        checkOutput("force_ready",     64'(in_ready_small), 64'd1);
        checkOutput("force_big_ovf",   64'(overflow_big),   64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
